// File: rtl/baud_frac_gen.sv
// Fractional-N baud tick generator: signed phase accumulator driving an oversample
// tick and a bit-rate tick. Define BAUD_FRAC_MID_EN to add the tick_mid bit-centre output.
module baud_frac_gen #(
  parameter int unsigned OSC        = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned WIDTH      = 32
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             enable,
  input  logic             restart,
  input  logic             cfg_load,
  input  logic [WIDTH-2:0] cfg_inc,
  input  logic [WIDTH-2:0] cfg_mod,
  output logic             cfg_err,
  output logic             tick_os,
  output logic             tick,
`ifdef BAUD_FRAC_MID_EN
  output logic             tick_mid,
`endif
  output logic [7:0]       os_phase
);

  localparam logic [WIDTH-2:0] INC_RST = (WIDTH-1)'(BAUD * OVERSAMPLE);
  localparam logic [WIDTH-2:0] MOD_RST = (WIDTH-1)'(OSC);
  localparam logic [7:0]       OS_LAST = 8'(OVERSAMPLE - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       os_cnt_q, os_cnt_d;
  logic [WIDTH-2:0] inc_q, inc_d;
  logic [WIDTH-2:0] mod_q, mod_d;
  logic             tick_os_q, tick_os_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic [WIDTH-1:0] inc_ext, mod_ext;
  logic             cfg_ok;

  assign inc_ext = {1'b0, inc_q};
  assign mod_ext = {1'b0, mod_q};

  // A non-negative accumulator means one oversample period has elapsed.
  always_comb begin
    acc_d     = acc_q;
    os_cnt_d  = os_cnt_q;
    tick_os_d = 1'b0;
    tick_d    = 1'b0;
    if (restart) begin
      acc_d    = '0;
      os_cnt_d = '0;
    end else if (enable) begin
      if (acc_q[WIDTH-1]) begin
        acc_d = acc_q + inc_ext;
      end else begin
        acc_d     = acc_q + inc_ext - mod_ext;
        tick_os_d = 1'b1;
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d = '0;
          tick_d   = 1'b1;
        end else begin
          os_cnt_d = os_cnt_q + 8'd1;
        end
      end
    end
  end

  // Runtime retune; the accumulator keeps its phase unless restart is also pulsed.
  always_comb begin
    cfg_ok    = (cfg_mod != '0) && (cfg_inc != '0) && (cfg_inc <= cfg_mod);
    inc_d     = inc_q;
    mod_d     = mod_q;
    cfg_err_d = 1'b0;
    if (cfg_load) begin
      if (cfg_ok) begin
        inc_d = cfg_inc;
        mod_d = cfg_mod;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      acc_q     <= '0;
      os_cnt_q  <= '0;
      inc_q     <= INC_RST;
      mod_q     <= MOD_RST;
      tick_os_q <= 1'b0;
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      os_cnt_q  <= os_cnt_d;
      inc_q     <= inc_d;
      mod_q     <= mod_d;
      tick_os_q <= tick_os_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef BAUD_FRAC_MID_EN
  localparam logic [7:0] OS_MID = 8'(OVERSAMPLE / 2);

  logic tick_mid_q, tick_mid_d;

  // OS_MID is never 0, so a restart (os_cnt_d = 0) cannot raise it.
  always_comb begin
    tick_mid_d = tick_os_d && (os_cnt_d == OS_MID);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      tick_mid_q <= 1'b0;
    end else begin
      tick_mid_q <= tick_mid_d;
    end
  end

  assign tick_mid = tick_mid_q;
`endif

  assign tick_os  = tick_os_q;
  assign tick     = tick_q;
  assign cfg_err  = cfg_err_q;
  assign os_phase = os_cnt_q;

endmodule

// File: tb/tb_baud_frac_gen.sv
// Bench for baud_frac_gen: directed and random stimulus against an arithmetic model where
// step m after a phase origin fires tick_os iff (m*inc) mod mod < inc.
module tb_baud_frac_gen;

  localparam int unsigned OSC  = 50000000;
  localparam int unsigned BAUD = 115200;
  localparam int unsigned OS   = 16;
  localparam int unsigned W    = 32;

  logic         clk = 1'b0;
  logic         reset_l = 1'b0;
  logic         enable = 1'b0;
  logic         restart = 1'b0;
  logic         cfg_load = 1'b0;
  logic [W-2:0] cfg_inc = '0;
  logic [W-2:0] cfg_mod = '0;
  logic         cfg_err;
  logic         tick_os;
  logic         tick;
  logic [7:0]   os_phase;
`ifdef BAUD_FRAC_MID_EN
  logic         tick_mid;
`endif

  int total = 0;
  int bad = 0;

  longint unsigned m_inc, m_mod, m_step, m_cnt;
  logic exp_os, exp_tick, exp_err, exp_mid;
  int cnt_os, cnt_tick;

  always #5 clk = ~clk;

  baud_frac_gen #(
    .OSC(OSC), .BAUD(BAUD), .OVERSAMPLE(OS), .WIDTH(W)
  ) dut (
    .clk(clk),
    .reset_l(reset_l),
    .enable(enable),
    .restart(restart),
    .cfg_load(cfg_load),
    .cfg_inc(cfg_inc),
    .cfg_mod(cfg_mod),
    .cfg_err(cfg_err),
    .tick_os(tick_os),
    .tick(tick),
`ifdef BAUD_FRAC_MID_EN
    .tick_mid(tick_mid),
`endif
    .os_phase(os_phase)
  );

  task automatic check_bit(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_inc    = longint'(BAUD) * longint'(OS);
    m_mod    = longint'(OSC);
    m_step   = 0;
    m_cnt    = 0;
    exp_os   = 1'b0;
    exp_tick = 1'b0;
    exp_err  = 1'b0;
    exp_mid  = 1'b0;
  endtask

  task automatic check_output();
    check_bit("tick_os", tick_os, exp_os);
    check_bit("tick", tick, exp_tick);
    check_bit("cfg_err", cfg_err, exp_err);
    check_val("os_phase", longint'(os_phase), longint'(m_cnt % longint'(OS)));
`ifdef BAUD_FRAC_MID_EN
    check_bit("tick_mid", tick_mid, exp_mid);
`endif
  endtask

  // An accepted load must coincide with restart so the model's phase origin stays valid.
  task automatic apply_stimulus(input logic en, input logic rs, input logic ld,
                                input logic [W-2:0] ci, input logic [W-2:0] cm);
    enable   = en;
    restart  = rs;
    cfg_load = ld;
    cfg_inc  = ci;
    cfg_mod  = cm;
    @(posedge clk);
    #1;
    exp_err = 1'b0;
    if (rs) begin
      m_step = 0; m_cnt = 0;
      exp_os = 1'b0; exp_tick = 1'b0; exp_mid = 1'b0;
    end else if (en) begin
      exp_os = ((m_step * m_inc) % m_mod) < m_inc;
      m_step++;
      if (exp_os) m_cnt++;
      exp_tick = exp_os && ((m_cnt % longint'(OS)) == 0);
      exp_mid  = exp_os && ((m_cnt % longint'(OS)) == longint'(OS / 2));
    end else begin
      exp_os = 1'b0; exp_tick = 1'b0; exp_mid = 1'b0;
    end
    if (ld) begin
      if (cm != '0 && ci != '0 && ci <= cm) begin
        m_inc = longint'(ci);
        m_mod = longint'(cm);
      end else begin
        exp_err = 1'b1;
      end
    end
    if (tick_os) cnt_os++;
    if (tick) cnt_tick++;
    check_output();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    longint lo;
    model_reset();
    enable = 1'b1;
    #12;
    check_bit("rst_tick_os", tick_os, 1'b0);
    check_bit("rst_tick", tick, 1'b0);
    check_val("rst_os_phase", longint'(os_phase), 0);
    check_bit("rst_cfg_err", cfg_err, 1'b0);
    reset_l = 1'b1;

    // Default rate from reset
    cnt_os = 0; cnt_tick = 0;
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
    check_bit("first_tick_os", tick_os, 1'b1);
    run(19999);
    lo = (longint'(20000) * m_inc) / m_mod;
    check_bit("default_os_rate", (cnt_os >= lo) && (cnt_os <= lo + 1), 1'b1);
    check_bit("default_tick_rate",
              (cnt_tick >= lo / OS) && (cnt_tick <= (lo + 1) / OS), 1'b1);

    // inc=3 mod=10 with restart: tick_os at steps 1,5,8 of every 10
    apply_stimulus(1'b1, 1'b1, 1'b1, 31'd3, 31'd10);
    for (int p = 0; p < 3; p++) begin
      cnt_os = 0;
      for (int s = 1; s <= 10; s++) begin
        apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
        check_bit("pattern_3_10", tick_os, (s == 1) || (s == 5) || (s == 8));
      end
      check_val("count_3_per_10", cnt_os, 3);
    end
    run(57);

    // Hold for 37 cycles then resume
    for (int i = 0; i < 37; i++) apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
    run(80);

    // Rejected loads keep the rate; cfg_load in hold still processed
    apply_stimulus(1'b1, 1'b0, 1'b1, 31'd11, 31'd10);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 31'd5, 31'd0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 31'd0, 31'd7);
    run(40);

    // inc == mod: tick_os every cycle, tick on the 16th after restart
    apply_stimulus(1'b1, 1'b1, 1'b1, 31'd10, 31'd10);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
    check_bit("restart_next_tick_os", tick_os, 1'b1);
    check_val("restart_phase_1", longint'(os_phase), 1);
    run(40);

    // Restart at an arbitrary phase with an uneven ratio
    apply_stimulus(1'b1, 1'b1, 1'b1, 31'd7, 31'd9);
    run(33);
    apply_stimulus(1'b1, 1'b1, 1'b0, '0, '0);
    run(60);

    // Random enable/restart/load traffic
    for (int i = 0; i < 3000; i++) begin
      logic en, rs, ld;
      logic [W-2:0] ci, cm;
      en = ($urandom % 8) != 0;
      rs = ($urandom % 64) == 0;
      ld = ($urandom % 40) == 0;
      ci = (W-1)'($urandom_range(0, 40));
      cm = (W-1)'($urandom_range(0, 40));
      if (ld && cm != '0 && ci != '0 && ci <= cm) rs = 1'b1;
      apply_stimulus(en, rs, ld, ci, cm);
    end

    // Async reset mid-run after a load
    apply_stimulus(1'b1, 1'b1, 1'b1, 31'd10, 31'd10);
    run(5);
    #1 reset_l = 1'b0;
    #1;
    check_bit("async_rst_tick_os", tick_os, 1'b0);
    check_bit("async_rst_tick", tick, 1'b0);
    check_val("async_rst_os_phase", longint'(os_phase), 0);
    @(posedge clk);
    #1 reset_l = 1'b1;
    model_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
    check_bit("post_rst_first_tick_os", tick_os, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0);
    check_bit("post_rst_second_idle", tick_os, 1'b0);
    run(1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/baud_frac_gen.md
Name: baud_frac_gen

Overview:
Fractional-N baud tick generator, successor to the fixed single-rate tick generator. Produces an oversample tick and a bit-rate tick for UART TX/RX and the I2C monitor serial path. Rate is set at build time by parameters and can be reprogrammed at runtime. Supports enable/hold, phase restart for start-bit alignment, and load validation.

Parameters:
OSC, 50000000, reset-default modulus (oscillator Hz)
BAUD, 115200, reset-default bit rate
OVERSAMPLE, 16, tick_os pulses per bit; legal 2..256
WIDTH, 32, signed accumulator width; must satisfy WIDTH >= clog2(max modulus)+2

Ports:
clk  in  1  system clock
reset_l  in  1  asynchronous active-low reset
enable  in  1  1 = run; 0 = hold accumulator and counter, ticks forced 0
restart  in  1  1-cycle pulse: realign phase
cfg_load  in  1  1-cycle pulse: load cfg_inc/cfg_mod
cfg_inc  in  WIDTH-1  new increment (BAUD*OVERSAMPLE, GCD-reduced)
cfg_mod  in  WIDTH-1  new modulus (OSC, GCD-reduced)
cfg_err  out  1  1-cycle pulse: load rejected
tick_os  out  1  oversample tick, 1 cycle wide
tick  out  1  bit-rate tick, 1 cycle wide
os_phase  out  8  current oversample index 0..OVERSAMPLE-1

Behaviour:
- Reset values: acc=0, os_cnt=0, inc=BAUD*OVERSAMPLE, mod=OSC. tick_os, tick and cfg_err are 0. os_phase=0.
- All outputs are registered. Only the async reset edge is combinational.
- Accumulator step, on each cycle with enable=1 and restart=0:
  - If acc[WIDTH-1]=1 (negative): acc += inc, tick_os <= 0.
  - Otherwise: acc += inc - mod, tick_os <= 1.
  - Arithmetic is WIDTH-bit two's complement. inc and mod are zero-extended.
- Oversample counter, on each cycle where tick_os is asserted:
  - os_cnt increments and wraps from OVERSAMPLE-1 to 0.
  - tick <= 1 in the same registered cycle that os_cnt wraps. Otherwise tick <= 0.
  - tick therefore coincides with a tick_os pulse.
- os_phase = os_cnt, zero-extended.
- Long-run tick_os rate = inc/mod per clock, exact, with no drift. The first tick_os occurs 1 cycle after reset release (acc=0 is non-negative).
- enable=0:
  - acc and os_cnt hold.
  - tick_os and tick are 0 on the next cycle.
  - Resuming continues the sequence exactly where it stopped.
- restart=1 (has priority over enable):
  - Next state: acc=0, os_cnt=0, tick_os=0, tick=0.
  - If enable=1 afterwards, tick_os fires on the cycle following the restart cycle.
  - tick fires on the OVERSAMPLE-th tick_os after restart.
- cfg_load=1:
  - Accepted only if cfg_mod != 0 and cfg_inc != 0 and cfg_inc <= cfg_mod. On accept, inc and mod update and are used from the next cycle.
  - acc is not cleared, so the phase continues. If a glitch-free retune matters, software pairs the load with restart.
  - On reject: inc and mod are unchanged, cfg_err <= 1 for 1 cycle.
- cfg_load and restart in the same cycle: both take effect. acc=0 and the new inc/mod apply from the next cycle.
- cfg_load while enable=0 is still processed.
- inc=mod is legal: tick_os is high every enabled cycle.
- Reset asserted mid-operation: all state returns to reset values immediately and asynchronously. Any loaded config is lost.

Optional Feature:
Macro: BAUD_FRAC_MID_EN.
- Defined: adds output tick_mid (1 bit). It pulses on the tick_os cycle where os_cnt transitions to OVERSAMPLE/2 (integer division), i.e. the bit centre after restart, for RX sampling. Reset value is 0 and it obeys enable/restart like tick.
- Not defined: the tick_mid port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then runtime load cfg_inc=3, cfg_mod=10, OVERSAMPLE=4, enable=1, restart -> exactly 3 tick_os per every 10 cycles; pattern from restart+1 is cycles 1,5,8 (period 10); tick on every 4th tick_os.
- Defaults OSC=50000000, BAUD=115200, OVERSAMPLE=16 over 1,000,000 cycles -> tick_os count 36864 ±1, tick count 2304 ±1.
- enable low for 37 cycles mid-stream -> no ticks during hold; after resume, the tick sequence equals the unpaused sequence shifted by exactly 37 cycles.
- cfg_load with cfg_inc=11, cfg_mod=10, then cfg_mod=0 -> cfg_err pulses once each; rate unchanged; cfg_inc=10, cfg_mod=10 -> tick_os every cycle.
- restart pulse at arbitrary phase with OVERSAMPLE=16 -> tick_os next cycle, os_phase=1 after it; tick on the 16th tick_os; with BAUD_FRAC_MID_EN, tick_mid on the 8th.
- reset_l low for 1 cycle mid-run after a config load -> outputs 0 immediately; default rate resumes, first tick_os 1 cycle after release.
